// File: rtl/shift_register_16_rot_pkg.sv
// Shared constants for the 16-bit rotating pattern generator.
package shift_register_16_rot_pkg;

  localparam int SHIFT_REG_WIDTH = 16;

endpackage : shift_register_16_rot_pkg

// File: rtl/shift_register_16_rot_bit_cell.sv
// One ring stage: a flop with synchronous reset, fed by the parallel-load bit
// or the previous stage.
module shift_reg_bit_cell (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic load_bit,
  input  logic ring_bit,
  output logic q
);

  logic q_r;

  // Stage flop: reset beats load, load beats rotate.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_r <= 1'b0;
    end else if (load) begin
      q_r <= load_bit;
    end else begin
      q_r <= ring_bit;
    end
  end

  assign q = q_r;

endmodule : shift_reg_bit_cell

// File: rtl/shift_register_16_rot.sv
// Parallel-load circular shift register; rotates left each clock and presents
// the top bit on shift_out, giving a 16-clock repeating output pattern.
module shift_register_16_rot
  import shift_register_16_rot_pkg::*;
#(
  parameter int WIDTH = SHIFT_REG_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] I,
  input  logic             load,
  output logic             shift_out
);

  logic [WIDTH-1:0] q_s;

  // Each stage takes its neighbour below; stage 0 closes the ring from the top.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ring
    shift_reg_bit_cell u_cell (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_bit (I[i]),
      .ring_bit (q_s[(i + WIDTH - 1) % WIDTH]),
      .q        (q_s[i])
    );
  end

  assign shift_out = q_s[WIDTH-1];

endmodule : shift_register_16_rot

// File: tb/tb_shift_register_16_rot.sv
// Randomized and directed checks of the rotating shift register against a
// model that tracks the loaded word and the clocks elapsed since the load.
module tb_shift_register_16_rot;

  logic        clock;
  logic        reset;
  logic [15:0] I;
  logic        load;
  logic        shift_out;

  int n_compared;
  int n_mismatched;

  logic [15:0] m_word;
  int          m_n;

  shift_register_16_rot dut (
    .clock     (clock),
    .reset     (reset),
    .I         (I),
    .load      (load),
    .shift_out (shift_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, observed, expected);
    end
  endtask

  // One clock edge: drive inputs, advance the model, then compare shift_out.
  task automatic step(input logic r, input logic l, input logic [15:0] w, input string tag);
    logic expected;
    reset = r;
    load  = l;
    I     = w;
    @(posedge clock);
    if (r) begin
      m_word = 16'h0000;
      m_n    = 0;
    end else if (l) begin
      m_word = w;
      m_n    = 0;
    end else begin
      m_n = m_n + 1;
    end
    expected = m_word[15 - (m_n % 16)];
    #1;
    check_bit(tag, shift_out, expected);
  endtask

  task automatic run_pattern(input logic [15:0] w, input int cycles, input string tag);
    step(1'b0, 1'b1, w, {tag, "_load"});
    for (int k = 0; k < cycles; k++) begin
      step(1'b0, 1'b0, 16'($urandom), tag);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_word       = 16'h0000;
    m_n          = 0;
    reset        = 1'b1;
    load         = 1'b0;
    I            = 16'h0000;

    step(1'b1, 1'b0, 16'h0000, "reset");
    step(1'b1, 1'b0, 16'h1234, "reset");
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 16'($urandom), "idle_zero");

    run_pattern(16'b1010101010101010, 34, "div2");
    run_pattern(16'b1100110011001100, 34, "div4");
    run_pattern(16'b1111000011110000, 34, "div8");
    run_pattern(16'b1000000010000000, 34, "p1_7");
    run_pattern(16'h8000,             34, "p1_15");
    run_pattern(16'b1110000000000000, 34, "p3_13");
    run_pattern(16'b1111111111100000, 34, "p11_5");

    step(1'b1, 1'b1, 16'hFFFF, "reset_wins");
    for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 16'($urandom), "after_reset_wins");

    run_pattern(16'b1111111111100000, 7, "p11_5_mid");
    step(1'b1, 1'b0, 16'hFFFF, "mid_reset");
    for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 16'($urandom), "after_mid_reset");

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h8000, "hold_load");
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 16'($urandom), "after_hold");
    run_pattern(16'h0001, 33, "reload_0001");

    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
           16'($urandom), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_shift_register_16_rot
